// File: rtl/microsequencer.sv
// ARC control-store address sequencer: CSAI, branch decode, DECODE former, PSR and memory-wait FSM.
// Define MICROSEQUENCER_MEM_TIMEOUT_EN to trap to TRAP_ADDRESS when a memory access never acknowledges.
//
// state | meaning
// RUN   | sequencing, one microinstruction per cycle
// WAIT  | frozen until main memory acknowledges (or the timeout traps)
module microsequencer #(
    parameter int unsigned DATAWIDTH_JUMPADDRESS = 11,
    parameter int unsigned DATAWIDTH_CONDITION   = 3,
    parameter int unsigned DATAWIDTH_IR          = 32,
    parameter int unsigned MEM_TIMEOUT_CYCLES    = 8,
    parameter logic [DATAWIDTH_JUMPADDRESS-1:0] TRAP_ADDRESS = 11'd2040
) (
    input  logic                             MICROSEQUENCER_CLOCK_50,
    input  logic                             MICROSEQUENCER_ResetInLow_In,
    input  logic [DATAWIDTH_CONDITION-1:0]   MICROSEQUENCER_Condition_InBus,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] MICROSEQUENCER_JumpAddress_InBus,
    input  logic                             MICROSEQUENCER_RD_In,
    input  logic                             MICROSEQUENCER_WRMain_In,
    input  logic                             MICROSEQUENCER_MemAck_In,
    input  logic [DATAWIDTH_IR-1:0]          MICROSEQUENCER_IR_InBus,
    input  logic [3:0]                       MICROSEQUENCER_ALUFlags_InBus,
    input  logic                             MICROSEQUENCER_SetCC_In,
    output logic [DATAWIDTH_JUMPADDRESS-1:0] MICROSEQUENCER_CSAddress_OutBus,
    output logic [3:0]                       MICROSEQUENCER_PSR_OutBus,
    output logic                             MICROSEQUENCER_Stall_Out,
    output logic                             MICROSEQUENCER_Timeout_Out
);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t                             state_q, state_d;
    logic [DATAWIDTH_JUMPADDRESS-1:0]   cs_addr_q, cs_addr_d;
    logic [3:0]                         psr_q, psr_d;

    logic                               mem_access;
    logic                               mem_ack;
    logic                               advance;
    logic                               branch_taken;
    logic [DATAWIDTH_JUMPADDRESS-1:0]   csai;
    logic [DATAWIDTH_JUMPADDRESS-1:0]   decode_addr;
    logic [DATAWIDTH_JUMPADDRESS-1:0]   next_addr;

    logic unused_ir;
    assign unused_ir = ^{MICROSEQUENCER_IR_InBus[29:25], MICROSEQUENCER_IR_InBus[18:14],
                         MICROSEQUENCER_IR_InBus[12:0]};

    assign mem_access  = MICROSEQUENCER_RD_In | MICROSEQUENCER_WRMain_In;
    assign mem_ack     = MICROSEQUENCER_MemAck_In;
    assign advance     = ((state_q == ST_RUN) && !mem_access) || mem_ack;
    assign csai        = cs_addr_q + DATAWIDTH_JUMPADDRESS'(1);
    // Opcode dispatch: op in bits 31:30, op3 in bits 24:19, word-aligned inside the upper half.
    assign decode_addr = DATAWIDTH_JUMPADDRESS'({1'b1, MICROSEQUENCER_IR_InBus[31:30],
                                                 MICROSEQUENCER_IR_InBus[24:19], 2'b00});

    always_comb begin
        branch_taken = 1'b0;
        case (MICROSEQUENCER_Condition_InBus)
            3'd1:    branch_taken = psr_q[3];
            3'd2:    branch_taken = psr_q[2];
            3'd3:    branch_taken = psr_q[1];
            3'd4:    branch_taken = psr_q[0];
            3'd5:    branch_taken = MICROSEQUENCER_IR_InBus[13];
            3'd6:    branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
        if (MICROSEQUENCER_Condition_InBus == 3'd7) begin
            next_addr = decode_addr;
        end else if (branch_taken) begin
            next_addr = MICROSEQUENCER_JumpAddress_InBus;
        end else begin
            next_addr = csai;
        end
    end

`ifdef MICROSEQUENCER_MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^{TRAP_ADDRESS, MEM_TIMEOUT_CYCLES};
`endif

    always_comb begin
        state_d   = state_q;
        cs_addr_d = cs_addr_q;
        psr_d     = psr_q;

        case (state_q)
            ST_RUN:  if (mem_access && !mem_ack) state_d = ST_WAIT;
            ST_WAIT: if (mem_ack) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase

        if (advance) begin
            cs_addr_d = next_addr;
            if (MICROSEQUENCER_SetCC_In) psr_d = MICROSEQUENCER_ALUFlags_InBus;
        end

`ifdef MICROSEQUENCER_MEM_TIMEOUT_EN
        wait_cnt_d = '0;
        timeout_d  = 1'b0;
        // An acknowledge on the limit edge takes the normal path above.
        if ((state_q == ST_WAIT) && !mem_ack) begin
            if (wait_cnt_q == CNT_W'(MEM_TIMEOUT_CYCLES - 1)) begin
                cs_addr_d = TRAP_ADDRESS;
                state_d   = ST_RUN;
                timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge MICROSEQUENCER_CLOCK_50 or negedge MICROSEQUENCER_ResetInLow_In) begin
        if (!MICROSEQUENCER_ResetInLow_In) begin
            state_q   <= ST_RUN;
            cs_addr_q <= '0;
            psr_q     <= '0;
        end else begin
            state_q   <= state_d;
            cs_addr_q <= cs_addr_d;
            psr_q     <= psr_d;
        end
    end

`ifdef MICROSEQUENCER_MEM_TIMEOUT_EN
    always_ff @(posedge MICROSEQUENCER_CLOCK_50 or negedge MICROSEQUENCER_ResetInLow_In) begin
        if (!MICROSEQUENCER_ResetInLow_In) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign MICROSEQUENCER_Timeout_Out = timeout_q;
`else
    assign MICROSEQUENCER_Timeout_Out = 1'b0;
`endif

    assign MICROSEQUENCER_CSAddress_OutBus = cs_addr_q;
    assign MICROSEQUENCER_PSR_OutBus       = psr_q;
    assign MICROSEQUENCER_Stall_Out        = mem_access & ~mem_ack;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed test-plan sequences plus randomized microwords
// compared against an arithmetic reference model of the sequencing rules.
module tb_microsequencer;

    localparam int TRAP = 2040;
    localparam int LIM  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  cond = '0;
    logic [10:0] jump = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] ir = '0;
    logic [3:0]  flags = '0;
    logic        setcc = 1'b0;
    logic [10:0] cs_addr;
    logic [3:0]  psr;
    logic        stall;
    logic        tout;

    int n_tests = 0;
    int n_fail  = 0;

    int m_addr = 0;
    int m_psr  = 0;
    bit m_wait = 0;
    int m_cnt  = 0;
    int m_to   = 0;

    microsequencer dut (
        .MICROSEQUENCER_CLOCK_50          (clk),
        .MICROSEQUENCER_ResetInLow_In     (rst_n),
        .MICROSEQUENCER_Condition_InBus   (cond),
        .MICROSEQUENCER_JumpAddress_InBus (jump),
        .MICROSEQUENCER_RD_In             (rd),
        .MICROSEQUENCER_WRMain_In         (wr),
        .MICROSEQUENCER_MemAck_In         (ack),
        .MICROSEQUENCER_IR_InBus          (ir),
        .MICROSEQUENCER_ALUFlags_InBus    (flags),
        .MICROSEQUENCER_SetCC_In          (setcc),
        .MICROSEQUENCER_CSAddress_OutBus  (cs_addr),
        .MICROSEQUENCER_PSR_OutBus        (psr),
        .MICROSEQUENCER_Stall_Out         (stall),
        .MICROSEQUENCER_Timeout_Out       (tout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_next(input int c, input int j, input logic [31:0] ir_v,
                                      input int psr_v, input int addr_v);
        int take;
        if (c == 7) return 1024 + int'(ir_v[31:30]) * 256 + int'(ir_v[24:19]) * 4;
        case (c)
            1, 2, 3, 4: take = (psr_v >> (4 - c)) & 1;
            5:          take = int'(ir_v[13]);
            6:          take = 1;
            default:    take = 0;
        endcase
        return (take != 0) ? j : (addr_v + 1) % 2048;
    endfunction

    task automatic drive(input int c, input int j, input int rd_v, input int wr_v, input int ack_v,
                         input logic [31:0] ir_v, input int fl, input int scc);
        cond  = 3'(c);
        jump  = 11'(j);
        rd    = rd_v[0];
        wr    = wr_v[0];
        ack   = ack_v[0];
        ir    = ir_v;
        flags = 4'(fl);
        setcc = scc[0];
    endtask

    // One clock cycle: check the combinational stall, step the model, check the registered state.
    task automatic tick();
        bit access, adv, trap;
        int nxt;
        #1;
        access = rd | wr;
        chk("stall", int'(stall), int'(access && !ack));
        nxt  = model_next(int'(cond), int'(jump), ir, m_psr, m_addr);
        adv  = ack || (!m_wait && !access);
        trap = 0;
`ifdef MICROSEQUENCER_MEM_TIMEOUT_EN
        if (m_wait && !ack) begin
            m_cnt++;
            trap = (m_cnt == LIM);
        end else begin
            m_cnt = 0;
        end
`endif
        m_to = 0;
        if (trap) begin
            m_addr = TRAP;
            m_wait = 0;
            m_cnt  = 0;
            m_to   = 1;
        end else if (adv) begin
            m_addr = nxt;
            if (setcc) m_psr = int'(flags);
            m_wait = 0;
        end else begin
            m_wait = 1;
        end
        @(posedge clk);
        #1;
        chk("addr", int'(cs_addr), m_addr);
        chk("psr", int'(psr), m_psr);
        chk("timeout", int'(tout), m_to);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_addr", int'(cs_addr), 0);
        chk("rst_psr", int'(psr), 0);
        chk("rst_timeout", int'(tout), 0);
        rst_n  = 1'b1;
        m_addr = 0;
        m_psr  = 0;
        m_wait = 0;
        m_cnt  = 0;
        m_to   = 0;
    endtask

    initial begin
        #1;
        do_reset();

        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
            tick();
            chk("csai_count", int'(cs_addr), i);
        end

        drive(6, 2047, 0, 0, 0, 32'h0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        tick();
        chk("csai_wrap", int'(cs_addr), 0);

        drive(7, 0, 0, 0, 0, 32'h8080_0000, 0, 0);
        tick();
        chk("decode", int'(cs_addr), 1600);
        drive(5, 1603, 0, 0, 0, 32'h0000_0000, 0, 0);
        tick();
        chk("ir13_clear", int'(cs_addr), 1601);
        drive(5, 1603, 0, 0, 0, 32'h0000_2000, 0, 0);
        tick();
        chk("ir13_set", int'(cs_addr), 1603);

        drive(6, 10, 0, 0, 0, 32'h0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0, 4'b0100, 1);
        tick();
        chk("psr_set", int'(psr), 4);
        drive(2, 40, 0, 0, 0, 32'h0, 0, 0);
        tick();
        chk("branch_z", int'(cs_addr), 40);

        drive(6, 10, 0, 0, 0, 32'h0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0, 4'b0100, 0);
        tick();
        drive(2, 40, 0, 0, 0, 32'h0, 0, 0);
        tick();
        chk("branch_z_untaken", int'(cs_addr), 12);

        drive(6, 0, 0, 0, 0, 32'h0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0, 32'h0, 0, 0);
            tick();
            chk("wait_hold", int'(cs_addr), 0);
        end
        drive(0, 0, 1, 0, 1, 32'h0, 0, 0);
        tick();
        chk("wait_release", int'(cs_addr), 1);
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        #1;
        chk("stall_clear", int'(stall), 0);

        drive(6, 0, 0, 0, 0, 32'h0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 32'h0, 0, 0);
        tick();
        tick();
        do_reset();
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        tick();
        chk("run_after_reset", int'(cs_addr), 1);

`ifdef MICROSEQUENCER_MEM_TIMEOUT_EN
        drive(6, 5, 0, 0, 0, 32'h0, 0, 0);
        tick();
        for (int i = 0; i < LIM; i++) begin
            drive(0, 0, 1, 0, 0, 32'h0, 0, 0);
            tick();
            chk("to_hold", int'(cs_addr), 5);
        end
        drive(0, 0, 1, 0, 0, 32'h0, 0, 0);
        tick();
        chk("to_trap", int'(cs_addr), TRAP);
        chk("to_pulse", int'(tout), 1);
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        tick();
        chk("to_pulse_end", int'(tout), 0);
        for (int i = 0; i < LIM; i++) begin
            drive(0, 0, 1, 0, 0, 32'h0, 0, 0);
            tick();
        end
        drive(0, 0, 1, 0, 1, 32'h0, 0, 0);
        tick();
        chk("ack_wins", int'(cs_addr), TRAP + 2);
        chk("ack_wins_pulse", int'(tout), 0);
`endif

        for (int i = 0; i < 600; i++) begin
            drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)),
                  int'($urandom_range(0, 9) < 3), int'($urandom_range(0, 9) < 2),
                  int'($urandom_range(0, 9) < 4), $urandom(),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
            tick();
            if (i == 300) begin
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
